// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and instruction register, reads the
// synchronous program memory under the external phase strobes.
module fetch_unit #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [7:0] HLT_OPCODE = 8'h7F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fetch,
    input  logic       decode,
    input  logic       execute,
    input  logic       writeback,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    input  logic [7:0] mem_rdata,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] pc,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       two_byte,
    output logic       instr_valid,
    output logic       halted,
    output logic       phase_error
);

    logic [2:0] strobe_count;
    logic       multi_strobe;
    logic [7:0] pc_plus_one;

    assign strobe_count = {2'b00, fetch} + {2'b00, decode}
                        + {2'b00, execute} + {2'b00, writeback};
    assign multi_strobe = (strobe_count > 3'd1);
    assign pc_plus_one  = pc + 8'd1;

    // Decode already requests the operand byte so it lands in the execute cycle.
    always_comb begin
        mem_addr = pc;
        mem_read = 1'b0;
        if (!halted && !multi_strobe) begin
            if (fetch) begin
                mem_read = 1'b1;
            end else if (decode) begin
                mem_addr = pc_plus_one;
                mem_read = mem_rdata[7];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= RESET_PC;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            two_byte    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            phase_error <= 1'b0;
        end else if (halted) begin
            pc          <= pc;
        end else if (multi_strobe) begin
            phase_error <= 1'b1;
        end else if (fetch) begin
            instr_valid <= 1'b0;
        end else if (decode) begin
            opcode      <= mem_rdata;
            two_byte    <= mem_rdata[7];
            pc          <= pc_plus_one;
        end else if (execute) begin
            instr_valid <= 1'b1;
            if (two_byte) begin
                operand <= mem_rdata;
                pc      <= pc_plus_one;
            end else begin
                operand <= 8'h00;
            end
        end else if (writeback) begin
            instr_valid <= 1'b0;
            // A taken branch wins over HLT so a branch can never halt the core.
            if (branch_taken) begin
                pc <= branch_target;
            end else if (opcode == HLT_OPCODE) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 8-bit CPU. It owns the program counter (PC) and the instruction register, and is driven by the one-hot `fetch`/`decode`/`execute`/`writeback` phase strobes from the phase `Decoder`. It issues reads to the synchronous program memory and presents the latched opcode and operand to the execute datapath. It also handles PC redirection for taken branches and the halt instruction.

## Interface
Parameters:
- `RESET_PC`, 8'h00: PC value after reset.
- `HLT_OPCODE`, 8'h7F: opcode that halts the fetch unit.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `fetch`  in  1  fetch-phase strobe from the phase `Decoder`.
- `decode`  in  1  decode-phase strobe.
- `execute`  in  1  execute-phase strobe.
- `writeback`  in  1  writeback-phase strobe.
- `mem_addr`  out  8  program memory address (combinational).
- `mem_read`  out  1  program memory read enable (combinational).
- `mem_rdata`  in  8  program memory read data, valid one cycle after the `mem_read` cycle.
- `branch_taken`  in  1  from the execute datapath; sampled at the writeback edge.
- `branch_target`  in  8  new PC when `branch_taken` is 1.
- `pc`  out  8  current PC (registered).
- `opcode`  out  8  latched opcode (registered).
- `operand`  out  8  latched operand byte (registered).
- `two_byte`  out  1  latched `opcode[7]`: the instruction carries an operand.
- `instr_valid`  out  1  one-cycle pulse; `opcode`/`operand` are complete.
- `halted`  out  1  sticky; set by HLT.
- `phase_error`  out  1  sticky; set when more than one phase strobe is high.

## Operation
- Instruction format: the opcode byte comes first. If `opcode[7]` is 1, an operand byte follows at PC+1.
- Fetch cycle (`fetch`=1, not halted):
  - `mem_addr` = `pc`, `mem_read` = 1.
  - At the edge: `instr_valid` <= 0.
- Decode cycle:
  - `mem_rdata` holds the opcode byte.
  - `mem_addr` = `pc`+1 (mod 256).
  - `mem_read` = `mem_rdata[7]`.
  - At the edge: `opcode` <= `mem_rdata`, `two_byte` <= `mem_rdata[7]`, `pc` <= `pc`+1.
- Execute cycle:
  - If `two_byte` is 1: at the edge, `operand` <= `mem_rdata` and `pc` <= `pc`+1.
  - If `two_byte` is 0: at the edge, `operand` <= 8'h00.
  - In both cases `instr_valid` <= 1 at this edge.
- Writeback cycle: `instr_valid` is 1 during this cycle. At the edge, `instr_valid` <= 0, and:
  - if `branch_taken` is 1: `pc` <= `branch_target` (this overrides the incremented PC);
  - else if `opcode` == `HLT_OPCODE`: `halted` <= 1 and `pc` holds.
- Halted state:
  - `mem_read` = 0 in every cycle.
  - All strobes are ignored.
  - `pc`, `opcode` and `operand` hold.
  - Only reset exits.
- Phase error: if two or more strobes are high at an edge, `phase_error` <= 1 and no other register changes at that edge. The flag is sticky until reset. Operation continues on later legal strobes.
- No strobe high: all registers hold. `mem_read` = 0 and `mem_addr` = `pc`.
- Reset (`reset`=0 at an edge):
  - `pc` <= `RESET_PC`; `opcode`, `operand` <= 8'h00; `two_byte`, `instr_valid`, `halted`, `phase_error` <= 0.
  - Reset dominates every strobe.
  - Reset mid-instruction discards the partial instruction.
- PC arithmetic is 8-bit and wraps 8'hFF -> 8'h00, including the operand address PC+1.

## Timing
- The phase strobes are registered outputs of the `Decoder` and advance one phase per clock.
- The memory read latency is exactly 1 cycle.
- Per instruction: 4 cycles.
  - The opcode is visible from the execute cycle onward.
  - The operand and `instr_valid` are visible in the writeback cycle.
- A redirected PC is visible in the next fetch cycle on `mem_addr`; there is no bubble.
- `mem_addr` and `mem_read` are combinational from the registered state, the strobes and `mem_rdata[7]`. All other outputs are registered.

## Test plan
- Reset, then one phase cycle with memory[00]=8'h12 -> `opcode`=8'h12, `two_byte`=0, `operand`=8'h00, `instr_valid` high only in writeback, `pc`=8'h01.
- Two-byte instruction, memory[01]=8'h85 and memory[02]=8'hA0 -> `opcode`=8'h85, `operand`=8'hA0, `pc`=8'h03; during decode, `mem_addr`=8'h02 and `mem_read`=1.
- `branch_taken`=1 with `branch_target`=8'h40 at writeback -> `pc`=8'h40, and the next fetch drives `mem_addr`=8'h40.
- PC at 8'hFF with memory[FF]=8'h90 and memory[00]=8'h11 -> `operand`=8'h11, `pc` wraps to 8'h01.
- Memory[pc]=8'h7F -> `halted`=1 after writeback; the following 8 phase cycles keep `mem_read`=0 and `pc` unchanged; `reset`=0 clears `halted` and sets `pc`=`RESET_PC`.
- `fetch` and `decode` high together -> `phase_error`=1 and `pc`/`opcode` unchanged; `reset` asserted during the execute phase -> all outputs return to their reset values at that edge.
